// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external combinational ALU between two requesters.
// Each operation is registered into the ALU, its result is captured, then returned on the owner's response channel.
module alu_arbiter #(
    parameter int VAR_WIDTH = 32,
    parameter int OP_WIDTH  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [OP_WIDTH-1:0]  req0_opcode,
    input  logic [VAR_WIDTH-1:0] req0_a,
    input  logic [VAR_WIDTH-1:0] req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [OP_WIDTH-1:0]  req1_opcode,
    input  logic [VAR_WIDTH-1:0] req1_a,
    input  logic [VAR_WIDTH-1:0] req1_b,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic [VAR_WIDTH-1:0] rsp0_data,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [VAR_WIDTH-1:0] rsp1_data,
    output logic [OP_WIDTH-1:0]  alu_opcode,
    output logic [VAR_WIDTH-1:0] alu_a,
    output logic [VAR_WIDTH-1:0] alu_b,
    input  logic [VAR_WIDTH-1:0] alu_out,
    output logic                 busy
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // the sender keeps valid and payload stable until then, and ready may depend on valid.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   last_grant;
    logic                   owner;
    logic                   grant_any;
    logic                   grant;
    logic                   req_fire;
    logic                   rsp_fire;
    logic [OP_WIDTH-1:0]    op_q;
    logic [VAR_WIDTH-1:0]   a_q;
    logic [VAR_WIDTH-1:0]   b_q;
    logic [VAR_WIDTH-1:0]   result_q;

    // On contention the port that was not served last wins.
    always_comb begin
        grant_any = req0_valid || req1_valid;
        grant     = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = (state == IDLE) && grant_any && !grant;
    assign req1_ready = (state == IDLE) && grant_any && grant;
    assign req_fire   = (state == IDLE) && grant_any;
    assign rsp_fire   = owner ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_fire) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
        end else begin
            state <= state_next;
            if (req_fire) begin
                owner      <= grant;
                last_grant <= grant;
                op_q       <= grant ? req1_opcode : req0_opcode;
                a_q        <= grant ? req1_a : req0_a;
                b_q        <= grant ? req1_b : req0_b;
            end
            if (state == EXEC) begin
                result_q <= alu_out;
            end
        end
    end

    assign alu_opcode = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp0_valid = (state == RESP) && !owner;
    assign rsp1_valid = (state == RESP) && owner;
    assign rsp0_data  = result_q;
    assign rsp1_data  = result_q;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a small ALU model answers the DUT, and a monitor checks every
// response against per-port expected queues plus an expected service-order queue.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_opcode, req1_opcode;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_data, rsp1_data;
    logic [4:0]  alu_opcode;
    logic [31:0] alu_a, alu_b, alu_out;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] exp0_q[$];
    logic [31:0] exp1_q[$];
    int          ord_q[$];

    alu_arbiter #(.VAR_WIDTH(32), .OP_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .busy(busy)
    );

    // External ALU stand-in: add, subtract, everything else xor.
    always_comb begin
        case (alu_opcode)
            5'h00:   alu_out = alu_a + alu_b;
            5'h11:   alu_out = alu_a - alu_b;
            default: alu_out = alu_a ^ alu_b;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_rsp(input int port, input logic [31:0] data);
        if (port == 0) exp0_q.push_back(data);
        else           exp1_q.push_back(data);
        ord_q.push_back(port);
    endtask

    task automatic pop_rsp(input int port, input logic [31:0] data);
        if (ord_q.size() == 0 || (port == 0 && exp0_q.size() == 0) || (port == 1 && exp1_q.size() == 0)) begin
            check(port == 0 ? "rsp0_unexpected" : "rsp1_unexpected", 32'd1, 32'd0);
        end else begin
            check("rsp_order", port, ord_q.pop_front());
            if (port == 0) check("rsp0_data", data, exp0_q.pop_front());
            else           check("rsp1_data", data, exp1_q.pop_front());
        end
    endtask

    // Monitor: a response transfers on the edge after a negedge that sees valid && ready.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp0_valid || rsp1_valid) check("rsp_exclusive", {31'd0, rsp0_valid & rsp1_valid}, 32'd0);
            if (rsp0_valid && rsp0_ready) pop_rsp(0, rsp0_data);
            if (rsp1_valid && rsp1_ready) pop_rsp(1, rsp1_data);
        end
    end

    task automatic send(input int port, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int hs_cyc);
        int   n;
        logic rdy;
        n = 0;
        if (port == 0) begin
            req0_opcode = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            req1_opcode = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
        @(negedge clk);
        rdy = (port == 0) ? req0_ready : req1_ready;
        while (!rdy && n < 60) begin
            @(negedge clk);
            rdy = (port == 0) ? req0_ready : req1_ready;
            n++;
        end
        check(port == 0 ? "req0_accept" : "req1_accept", {31'd0, rdy}, 32'd1);
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        if (port == 0) req0_valid = 1'b0;
        else           req1_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || exp0_q.size() != 0 || exp1_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int h0, h1, h2, d0, d1, n;
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_opcode = '0; req0_a = '0; req0_b = '0;
        req1_opcode = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        #12;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        check("reset_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        check("reset_alu_opcode", {27'd0, alu_opcode}, 32'd0);
        check("reset_alu_a", alu_a, 32'd0);
        check("reset_rsp0_data", rsp0_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req0_ready", {31'd0, req0_ready}, 32'd0);
        @(posedge clk);
        #1;

        // Contention right after reset: req0 first.
        expect_rsp(0, 32'd2);
        expect_rsp(1, 32'd4);
        fork
            send(0, 5'h00, 32'd1, 32'd1, d0);
            send(1, 5'h00, 32'd2, 32'd2, d1);
        join
        drain();

        // Single op with latency checks.
        expect_rsp(0, 32'd8);
        send(0, 5'h00, 32'd5, 32'd3, d0);
        @(negedge clk);
        check("exec_busy", {31'd0, busy}, 32'd1);
        check("exec_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        check("exec_alu_a", alu_a, 32'd5);
        check("exec_alu_b", alu_b, 32'd3);
        @(negedge clk);
        check("resp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        check("resp_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        drain();

        // req0 was served last, so contention now goes to req1.
        expect_rsp(1, 32'd11);
        expect_rsp(0, 32'd7);
        fork
            send(0, 5'h00, 32'd3, 32'd4, d0);
            send(1, 5'h00, 32'd5, 32'd6, d1);
        join
        drain();

        // Subtract opcode passes through unmodified.
        expect_rsp(1, 32'd7);
        send(1, 5'h11, 32'd10, 32'd3, d1);
        @(negedge clk);
        check("sub_alu_opcode", {27'd0, alu_opcode}, 32'h11);
        check("sub_alu_a", alu_a, 32'd10);
        drain();

        // Backpressure on rsp0 while req1 waits.
        rsp0_ready = 1'b0;
        expect_rsp(0, 32'd123);
        expect_rsp(1, 32'd3);
        fork
            send(1, 5'h00, 32'd1, 32'd2, d1);
            begin
                send(0, 5'h00, 32'd100, 32'd23, d0);
                n = 0;
                @(negedge clk);
                while (!rsp0_valid && n < 10) begin
                    @(negedge clk);
                    n++;
                end
                repeat (4) begin
                    check("bp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
                    check("bp_rsp0_data", rsp0_data, 32'd123);
                    check("bp_busy", {31'd0, busy}, 32'd1);
                    check("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                rsp0_ready = 1'b1;
                @(negedge clk);
                @(negedge clk);
                check("bp_release_valid", {31'd0, rsp0_valid}, 32'd0);
                check("bp_release_busy", {31'd0, busy}, 32'd0);
                check("bp_release_req1_ready", {31'd0, req1_ready}, 32'd1);
            end
        join
        drain();

        // Reset during EXEC drops the transaction.
        send(0, 5'h11, 32'd9, 32'd7, d0);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        check("mid_reset_busy", {31'd0, busy}, 32'd0);
        check("mid_reset_alu_opcode", {27'd0, alu_opcode}, 32'd0);
        check("mid_reset_alu_a", alu_a, 32'd0);
        check("mid_reset_alu_b", alu_b, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_no_rsp", {31'd0, rsp0_valid | rsp1_valid}, 32'd0);
        @(posedge clk);
        #1;
        expect_rsp(0, 32'd3);
        expect_rsp(1, 32'd9);
        fork
            send(0, 5'h00, 32'd1, 32'd2, d0);
            send(1, 5'h00, 32'd4, 32'd5, d1);
        join
        drain();

        // Streaming on req0: one accept every three cycles.
        expect_rsp(0, 32'd30);
        expect_rsp(0, 32'd42);
        expect_rsp(0, 32'hFF);
        send(0, 5'h00, 32'd10, 32'd20, h0);
        send(0, 5'h11, 32'd50, 32'd8, h1);
        send(0, 5'h07, 32'hF0, 32'h0F, h2);
        check("stream_gap1", h1 - h0, 32'd3);
        check("stream_gap2", h2 - h1, 32'd3);
        drain();
        repeat (3) @(negedge clk);
        check("idle_hold_opcode", {27'd0, alu_opcode}, 32'h07);
        check("idle_hold_alu_a", alu_a, 32'hF0);

        check("leftover_expected", exp0_q.size() + exp1_q.size() + ord_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU instance between two requesters, e.g. port 0 = execute stage, port 1 = address/PC-update logic.
- Each requester issues {opcode, a, b} over a valid/ready request channel and receives the result over a valid/ready response channel.
- The block registers operands and drives the external ALU's opcode/a/b inputs.
- It captures the ALU out bus, returns the result to the granted requester, and arbitrates round-robin.

Parameters:
- VAR_WIDTH, 32, operand/result width (matches ALU VAR_WIDTH).
- OP_WIDTH, 5, ALU opcode width (matches ALU OP_WIDTH).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_opcode  input  OP_WIDTH  ALU opcode from requester 0.
- req0_a  input  VAR_WIDTH  operand a from requester 0.
- req0_b  input  VAR_WIDTH  operand b from requester 0.
- req1_valid / req1_ready / req1_opcode / req1_a / req1_b  as above, requester 1.
- rsp0_valid  output  1  result available for requester 0.
- rsp0_ready  input  1  requester 0 consumes result.
- rsp0_data  output  VAR_WIDTH  result for requester 0.
- rsp1_valid / rsp1_ready / rsp1_data  as above, requester 1.
- alu_opcode  output  OP_WIDTH  to ALU opcode.
- alu_a  output  VAR_WIDTH  to ALU a.
- alu_b  output  VAR_WIDTH  to ALU b.
- alu_out  input  VAR_WIDTH  from ALU out (combinational).
- busy  output  1  high when state != IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset value: IDLE.
- IDLE grant:
  - Only reqN_valid set: grant N.
  - Both set: grant the port not granted last. last_grant resets to 1, so req0 wins first.
  - reqN_ready is combinational: (state==IDLE) && grant==N. At most one ready is high per cycle.
  - On handshake (valid && ready): latch opcode/a/b into the operand registers, record owner=N and last_grant=N, go to EXEC.
- EXEC (one cycle):
  - alu_opcode/alu_a/alu_b are driven from the operand registers, so they are registered outputs.
  - On the clock edge, capture alu_out into the result register, set rspOwner_valid=1, go to RESP.
- RESP:
  - Hold rspOwner_valid=1 and rspOwner_data stable until rspOwner_ready=1.
  - On that edge, clear valid and go to IDLE.
  - The non-owner rsp_valid is always 0.
- Latency and throughput:
  - Request handshake at edge T, rsp_valid high after edge T+1, visible from cycle T+2.
  - Best throughput is one op per 3 cycles.
  - No new request is accepted outside IDLE; both readys are 0 in EXEC/RESP.
- Requester rules:
  - Holds valid and payload stable until ready.
  - Must not drop valid before handshake.
  - The arbiter does not check these rules.
- rspN_ready while rspN_valid=0: ignored.
- Operand registers hold their last values when idle. alu_* outputs keep the last operation (no toggling when idle).
- Reset values:
  - All operand registers and rsp data registers are 0.
  - rsp*_valid = 0, busy = 0, last_grant = 1.
- Reset mid-operation (EXEC or RESP): the transaction is dropped with no response. The arbiter returns to IDLE with all outputs at reset values.
- Opcode and operands pass through unmodified. The arbiter does no decoding, and results are whatever the ALU produces.

Test Plan:
- Single op: req0 opcode=5'h00, a=5, b=3 -> req0_ready in cycle 0, rsp0_valid from cycle 2 with rsp0_data=8, rsp1_valid stays 0.
- Subtract passthrough: req1 opcode=5'h11 (func7 ext, R-type, base 000), a=10, b=3 -> alu_opcode=5'h11, rsp1_data=7.
- Simultaneous requests after reset: both valid, req0 add 1+1, req1 add 2+2 -> req0 served first (rsp0_data=2), then req1 accepted in next IDLE (rsp1_data=4). Repeat both valid -> req1 first this time (alternation).
- Backpressure: rsp0_ready held low 4 cycles -> rsp0_valid/data stable, busy=1, req1_ready=0 throughout. Raise rsp0_ready -> valid drops next edge, FSM in IDLE.
- Reset mid-op: assert rst_n=0 during EXEC -> rsp0_valid=0, busy=0, alu_a/alu_b/alu_opcode=0 immediately. After release, no stale response; next request is served normally with req0 priority.
- Streaming: req0 held valid with 3 back-to-back ops while req1 idle -> accepts every 3 cycles with rsp0_ready=1, results in order.
